sync_db: RTL and testbench
==========================

SYNC_DB -- requirements
Module: sync_db

Interface
REQ-001 Parameter WIDTH, default 1: number of independent input channels, >= 1.
REQ-002 Parameter NUM_FF, default 2: synchroniser flops per channel, >= 2.
REQ-003 Parameter INIT_VALUE, default 0: WIDTH-bit reset value for every synchroniser flop and sig_o, per channel bit.
REQ-004 Parameter DB_CYCLES, default 4: tick-qualified stable cycles required before an output change, >= 1.
REQ-005 clk  input  1  single clock; all state on its rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 tick_i  input  1  debounce count enable; tie high to count every clk cycle.
REQ-008 sig_i  input  WIDTH  asynchronous raw inputs, e.g. footswitches or toggles.
REQ-009 sig_o  output  WIDTH  synchronised, debounced level per channel, registered.
REQ-010 rise_o  output  WIDTH  one-cycle pulse per channel when sig_o goes 0->1.
REQ-011 fall_o  output  WIDTH  one-cycle pulse per channel when sig_o goes 1->0.

Function
REQ-012 Each channel i SHALL pass sig_i[i] through a NUM_FF-deep flop chain; s[i] is the last flop output.
REQ-013 Each channel SHALL hold a debounce counter of width $clog2(DB_CYCLES+1) bits.
REQ-014 When s[i] == sig_o[i], the counter SHALL clear to 0 on the next edge, regardless of tick_i.
REQ-015 When s[i] != sig_o[i], tick_i=1, and cnt < DB_CYCLES-1, the counter SHALL increment.
REQ-016 When s[i] != sig_o[i], tick_i=1, and cnt == DB_CYCLES-1, the channel SHALL update on that edge: sig_o[i] <= s[i], counter <= 0, and the matching rise_o[i] or fall_o[i] <= 1.
REQ-017 When s[i] != sig_o[i] and tick_i=0, the counter SHALL hold its value.
REQ-018 rise_o/fall_o SHALL be high only in the cycle immediately following the sig_o change; otherwise 0.
REQ-019 rise_o[i] and fall_o[i] SHALL never be high together.
REQ-020 Latency with tick_i held high: a clean step on sig_i sampled at edge 0 SHALL change sig_o at edge NUM_FF+DB_CYCLES-1.
REQ-021 With tick_i held high, any s[i] excursion shorter than DB_CYCLES cycles SHALL leave sig_o[i] unchanged and produce no pulse.
REQ-022 Channels SHALL be fully independent; simultaneous changes on several channels SHALL each follow REQ-014..REQ-018.
REQ-023 The counter SHALL never exceed DB_CYCLES-1, so no wrap-around can occur.
REQ-024 DB_CYCLES=1 SHALL give sig_o[i] = s[i] delayed by one tick-qualified cycle.

Reset
REQ-025 On rst=1 at a clock edge, all synchroniser flops and sig_o SHALL load INIT_VALUE, counters SHALL load 0, and rise_o/fall_o SHALL load 0.
REQ-026 Reset SHALL take priority over any in-progress count; no pulse SHALL be generated by reset or in the first cycle after it.
REQ-027 sig_i SHALL be ignored while rst=1.

Structure
REQ-028 Package sync_db_pkg SHALL hold the counter-width function and the parameter legality checks (NUM_FF>=2, DB_CYCLES>=1, WIDTH>=1), reported as elaboration errors.
REQ-029 Sub-module sync_db_chan SHALL implement one channel (chain, counter, level, pulses); sync_db SHALL instantiate WIDTH copies via generate.

Verification
Common setup: WIDTH=2, NUM_FF=2, DB_CYCLES=4, INIT_VALUE=2'b00, tick_i=1 unless stated.
REQ-030 Clean step: sig_i[0] 0->1 before edge 0 -> sig_o[0]=1 after edge 5; rise_o[0]=1 for exactly that one cycle; channel 1 unaffected.
REQ-031 Glitch rejection: sig_i[1]=1 for 3 cycles then 0 -> sig_o[1] stays 0; no rise_o or fall_o.
REQ-032 Tick gating: tick_i=1 every 4th cycle, step sig_i[0] -> sig_o[0] changes at the edge of the 4th tick after s[0] changes, not before.
REQ-033 Reset mid-count: rst=1 for one cycle after 2 counts -> sig_o, counter and pulses return to INIT_VALUE/0; a held input re-qualifies a full NUM_FF+DB_CYCLES-1 edges after reset release.
REQ-034 INIT_VALUE=2'b11: after rst, sig_o=2'b11 with no pulses; drive sig_i=2'b00 -> fall_o=2'b11 in the same cycle.

Source files
------------

// File: rtl/sync_db_pkg.sv
// Shared helpers for the sync_db debouncer: counter sizing and parameter legality.
package sync_db_pkg;

  function automatic int cnt_width(input int db_cycles);
    return $clog2(db_cycles + 32'sd1);
  endfunction

  function automatic bit params_ok(input int width, input int num_ff, input int db_cycles);
    return (width >= 32'sd1) && (num_ff >= 32'sd2) && (db_cycles >= 32'sd1);
  endfunction

endpackage

// File: rtl/sync_db_chan.sv
// One debounce channel: synchroniser chain, tick-qualified stability counter,
// registered level and edge pulses.
module sync_db_chan
  import sync_db_pkg::*;
#(
  parameter int   NUM_FF    = 2,
  parameter int   DB_CYCLES = 4,
  parameter logic INIT_BIT  = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int CW = cnt_width(DB_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 32'sd1);

  logic [NUM_FF-1:0] sync_r;
  logic [CW-1:0]     cnt_r;
  logic              s_s;

  assign s_s = sync_r[NUM_FF-1];

  // Synchronise, count stable ticks of disagreement, commit the new level on the last one.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_r <= {NUM_FF{INIT_BIT}};
      level  <= INIT_BIT;
      cnt_r  <= {CW{1'b0}};
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync_r <= {sync_r[NUM_FF-2:0], din};
      rise   <= 1'b0;
      fall   <= 1'b0;
      if (s_s == level) begin
        cnt_r <= {CW{1'b0}};
      end else if (tick) begin
        if (cnt_r == CNT_LAST) begin
          level <= s_s;
          cnt_r <= {CW{1'b0}};
          rise  <= s_s;
          fall  <= ~s_s;
        end else begin
          cnt_r <= cnt_r + CW'(1);
        end
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

endmodule

// File: rtl/sync_db.sv
// Multi-channel synchroniser and debouncer: WIDTH independent sync_db_chan copies.
module sync_db
  import sync_db_pkg::*;
#(
  parameter int               WIDTH      = 1,
  parameter int               NUM_FF     = 2,
  parameter logic [WIDTH-1:0] INIT_VALUE = {WIDTH{1'b0}},
  parameter int               DB_CYCLES  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_i,
  input  logic [WIDTH-1:0] sig_i,
  output logic [WIDTH-1:0] sig_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o
);

  if (!params_ok(WIDTH, NUM_FF, DB_CYCLES)) begin : g_bad_params
    $error("sync_db: illegal parameters (need WIDTH>=1, NUM_FF>=2, DB_CYCLES>=1)");
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    sync_db_chan #(
      .NUM_FF    (NUM_FF),
      .DB_CYCLES (DB_CYCLES),
      .INIT_BIT  (INIT_VALUE[i])
    ) u_chan (
      .clk   (clk),
      .rst   (rst),
      .tick  (tick_i),
      .din   (sig_i[i]),
      .level (sig_o[i]),
      .rise  (rise_o[i]),
      .fall  (fall_o[i])
    );
  end

endmodule

// File: tb/tb_sync_db.sv
// Bench for sync_db: three configurations checked every cycle against a
// delay-line plus tick-counting model, with hand-computed edge expectations.
module tb_sync_db;

  localparam int NI = 3;

  logic clk = 1'b0;
  logic rst;
  logic tick;
  logic [1:0] sig_a, sig_b;
  logic       sig_c;
  logic [1:0] so_a, ri_a, fa_a, so_b, ri_b, fa_b;
  logic       so_c, ri_c, fa_c;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  sync_db #(.WIDTH(2), .NUM_FF(2), .INIT_VALUE(2'b00), .DB_CYCLES(4)) dut_a (
    .clk(clk), .rst(rst), .tick_i(tick), .sig_i(sig_a),
    .sig_o(so_a), .rise_o(ri_a), .fall_o(fa_a));

  sync_db #(.WIDTH(2), .NUM_FF(2), .INIT_VALUE(2'b11), .DB_CYCLES(4)) dut_b (
    .clk(clk), .rst(rst), .tick_i(tick), .sig_i(sig_b),
    .sig_o(so_b), .rise_o(ri_b), .fall_o(fa_b));

  sync_db #(.WIDTH(1), .NUM_FF(3), .INIT_VALUE(1'b0), .DB_CYCLES(1)) dut_c (
    .clk(clk), .rst(rst), .tick_i(tick), .sig_i(sig_c),
    .sig_o(so_c), .rise_o(ri_c), .fall_o(fa_c));

  // Model: per instance configuration and state.
  int         nff  [NI] = '{2, 2, 3};
  int         dbc  [NI] = '{4, 4, 1};
  int         wid  [NI] = '{2, 2, 1};
  logic [1:0] initv[NI] = '{2'b00, 2'b11, 2'b00};

  logic       m_line[NI][2][4];   // raw input delay line, [0] newest
  int         m_ticks[NI][2];     // tick-qualified cycles spent disagreeing
  logic [1:0] m_out[NI], m_rise[NI], m_fall[NI];

  function automatic logic [1:0] raw_in(int i);
    case (i)
      0: return sig_a;
      1: return sig_b;
      default: return {1'b0, sig_c};
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      m_out[i] = initv[i];
      m_rise[i] = 2'b00;
      m_fall[i] = 2'b00;
      for (int c = 0; c < 2; c++) begin
        m_ticks[i][c] = 0;
        for (int k = 0; k < 4; k++) m_line[i][c][k] = initv[i][c];
      end
    end
  endtask

  task automatic model_edge();
    logic [1:0] in_v;
    logic       s;
    if (rst) begin
      model_reset();
      return;
    end
    for (int i = 0; i < NI; i++) begin
      in_v = raw_in(i);
      m_rise[i] = 2'b00;
      m_fall[i] = 2'b00;
      for (int c = 0; c < wid[i]; c++) begin
        s = m_line[i][c][nff[i]-1];
        if (s == m_out[i][c]) begin
          m_ticks[i][c] = 0;
        end else if (tick) begin
          m_ticks[i][c]++;
          if (m_ticks[i][c] == dbc[i]) begin
            m_out[i][c] = s;
            m_ticks[i][c] = 0;
            if (s) m_rise[i][c] = 1'b1;
            else   m_fall[i][c] = 1'b1;
          end
        end
        for (int k = 3; k > 0; k--) m_line[i][c][k] = m_line[i][c][k-1];
        m_line[i][c][0] = in_v[c];
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("a.sig_o",  {30'd0, so_a}, {30'd0, m_out[0]});
    check("a.rise_o", {30'd0, ri_a}, {30'd0, m_rise[0]});
    check("a.fall_o", {30'd0, fa_a}, {30'd0, m_fall[0]});
    check("b.sig_o",  {30'd0, so_b}, {30'd0, m_out[1]});
    check("b.rise_o", {30'd0, ri_b}, {30'd0, m_rise[1]});
    check("b.fall_o", {30'd0, fa_b}, {30'd0, m_fall[1]});
    check("c.sig_o",  {31'd0, so_c}, {30'd0, m_out[2]});
    check("c.rise_o", {31'd0, ri_c}, {30'd0, m_rise[2]});
    check("c.fall_o", {31'd0, fa_c}, {30'd0, m_fall[2]});
  endtask

  // One clock: model follows the edge, then DUT is compared 1 time unit later.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  initial begin
    model_reset();
    rst = 1'b1; tick = 1'b1;
    sig_a = 2'b00; sig_b = 2'b11; sig_c = 1'b0;
    @(negedge clk);
    step(); step();
    check("reset a sig_o", {30'd0, so_a}, 32'h0);
    check("reset b sig_o", {30'd0, so_b}, 32'h3);
    check("reset b pulses", {28'd0, ri_b, fa_b}, 32'h0);
    rst = 1'b0;
    step();
    check("post-reset b pulses", {28'd0, ri_b, fa_b}, 32'h0);
    for (int k = 0; k < 4; k++) step();

    // Clean step on channel 0: change at edge 5, one-cycle rise.
    sig_a = 2'b01;
    for (int k = 0; k < 8; k++) begin
      step();
      if (k == 4) check("step a before edge5", {30'd0, so_a}, 32'h0);
      if (k == 5) check("step a edge5 sig/rise", {28'd0, so_a, ri_a}, 32'h5);
      if (k == 6) check("step a rise width", {30'd0, ri_a}, 32'h0);
    end

    // Glitch on channel 1 for three cycles.
    sig_a = 2'b11;
    step(); step(); step();
    sig_a = 2'b01;
    for (int k = 0; k < 10; k++) step();
    check("glitch a sig_o", {30'd0, so_a}, 32'h1);

    // Tick every 4th cycle: fall at the 4th tick after s changes (edge 15).
    sig_a = 2'b00;
    for (int k = 0; k < 20; k++) begin
      tick = (k % 4 == 3);
      step();
      if (k == 14) check("tick a before edge15", {30'd0, so_a}, 32'h1);
      if (k == 15) check("tick a edge15 sig/fall", {28'd0, so_a, fa_a}, 32'h1);
    end
    tick = 1'b1;

    // Reset after two counts; held input re-qualifies 5 edges after release.
    sig_a = 2'b10;
    for (int k = 0; k < 14; k++) begin
      rst = (k == 4);
      step();
      if (k == 4) check("midreset a sig/pulses", {26'd0, so_a, ri_a, fa_a}, 32'h0);
      if (k == 9) check("midreset a before requal", {30'd0, so_a}, 32'h0);
      if (k == 10) check("midreset a requal", {28'd0, so_a, ri_a}, 32'hA);
    end
    rst = 1'b0;

    // INIT 11 instance: both channels fall together.
    sig_b = 2'b00;
    for (int k = 0; k < 8; k++) begin
      step();
      if (k == 4) check("b before fall", {28'd0, so_b, fa_b}, 32'hC);
      if (k == 5) check("b fall both", {28'd0, so_b, fa_b}, 32'h3);
    end

    // DB_CYCLES=1, NUM_FF=3: follows s one cycle later.
    sig_c = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      if (k == 2) check("c before edge3", {31'd0, so_c}, 32'h0);
      if (k == 3) check("c edge3 sig/rise", {30'd0, so_c, ri_c}, 32'h3);
      if (k == 4) check("c rise width", {31'd0, ri_c}, 32'h0);
    end
    sig_c = 1'b0; step();
    sig_c = 1'b1;
    for (int k = 0; k < 6; k++) step();

    // Simultaneous opposite changes on both channels of instance a.
    sig_a = 2'b01;
    for (int k = 0; k < 8; k++) begin
      step();
      if (k == 5) check("a simul sig/rise/fall", {26'd0, so_a, ri_a, fa_a}, 32'h16);
    end

    // Short directed pattern with gapped ticks across all instances.
    for (int k = 0; k < 40; k++) begin
      tick = (k % 3 != 1);
      sig_a = (k < 12) ? 2'b10 : ((k < 15) ? 2'b01 : 2'b11);
      sig_b = (k % 7 < 5) ? 2'b01 : 2'b10;
      sig_c = (k % 2 == 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
